// File: rtl/dcs_pkg.sv
// Shared types and constants for the DCS transmit chain.
package dcs_pkg;

  localparam int DCS_FRAME_W = 96;
  localparam int DCS_SYNC_W  = 16;
  localparam logic [DCS_SYNC_W-1:0] DCS_SYNC_WORD = 16'hF0A5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_GAP     = 2'd3
  } dcs_state_e;

  // One down-counter serves every phase, so it must hold the longest phase length.
  function automatic int dcs_cnt_w(input int sync_w, input int data_w, input int gap_cycles);
    int m;
    m = 2;
    if (sync_w > m) m = sync_w;
    if (data_w > m) m = data_w;
    if (gap_cycles > m) m = gap_cycles;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/dcs_tx_serializer_if.sv
// Codeword handshake plus serial line outputs of the DCS transmit serializer.
interface dcs_tx_serializer_if
  import dcs_pkg::*;
#(
  parameter int DATA_W = DCS_FRAME_W
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              tx_bit;
  logic              tx_en;
  logic              frame_start;
  logic              frame_done;
  logic              busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, tx_bit, tx_en, frame_start, frame_done, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, tx_bit, tx_en, frame_start, frame_done, busy
  );

endinterface

// File: rtl/dcs_piso.sv
// Parallel-load, MSB-first shift register; load wins over shift.
module dcs_piso #(
  parameter int W = 96
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         msb_o
);

  logic [W-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (reset)        sr_q <= '0;
    else if (load_i)  sr_q <= data_i;
    else if (shift_i) sr_q <= {sr_q[W-2:0], 1'b0};
  end

  assign msb_o = sr_q[W-1];

endmodule

// File: rtl/dcs_tx_serializer.sv
// Frames an interleaved codeword as sync word + payload, MSB first, followed by an idle guard gap.
module dcs_tx_serializer
  import dcs_pkg::*;
#(
  parameter int                DATA_W     = DCS_FRAME_W,
  parameter int                SYNC_W     = DCS_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_WORD  = SYNC_W'(DCS_SYNC_WORD),
  parameter int                GAP_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  dcs_tx_serializer_if.slave  bus
);

  localparam int CNT_W = dcs_cnt_w(SYNC_W, DATA_W, GAP_CYCLES);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  dcs_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic             in_ready_q, in_ready_d;
  logic             tx_bit_q, tx_bit_d;
  logic             tx_en_q, tx_en_d;
  logic             fstart_q, fstart_d;
  logic             fdone_q, fdone_d;
  logic             busy_q, busy_d;
  logic             piso_load, piso_shift, piso_msb;
  logic [SYNC_W-1:0] sync_sh;

  dcs_piso #(.W(DATA_W)) u_piso (
    .clk     (clk),
    .reset   (reset),
    .load_i  (piso_load),
    .shift_i (piso_shift),
    .data_i  (bus.in_data),
    .msb_o   (piso_msb)
  );

  assign cnt_dec = cnt_q - CNT_W'(1);
  // Counter value equals the index of the bit currently on the line, so the next bit is cnt-1.
  assign sync_sh = SYNC_WORD >> cnt_dec;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_ready_d = in_ready_q;
    busy_d     = busy_q;
    tx_bit_d   = 1'b0;
    tx_en_d    = 1'b0;
    fstart_d   = 1'b0;
    fdone_d    = 1'b0;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
        if (bus.in_valid && in_ready_q) begin
          state_d    = ST_SYNC;
          cnt_d      = SYNC_LAST;
          piso_load  = 1'b1;
          tx_en_d    = 1'b1;
          tx_bit_d   = SYNC_WORD[SYNC_W-1];
          fstart_d   = 1'b1;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_SYNC: begin
        tx_en_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d    = cnt_dec;
          tx_bit_d = sync_sh[0];
        end else begin
          state_d    = ST_PAYLOAD;
          cnt_d      = DATA_LAST;
          tx_bit_d   = piso_msb;
          piso_shift = 1'b1;
          fdone_d    = (DATA_W == 1);
        end
      end
      ST_PAYLOAD: begin
        if (cnt_q != '0) begin
          tx_en_d    = 1'b1;
          cnt_d      = cnt_dec;
          tx_bit_d   = piso_msb;
          piso_shift = 1'b1;
          fdone_d    = (cnt_q == CNT_W'(1));
        end else if (GAP_CYCLES > 0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LAST;
        end else begin
          state_d    = ST_IDLE;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
      end
      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_dec;
        end else begin
          state_d    = ST_IDLE;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      in_ready_q <= 1'b1;
      tx_bit_q   <= 1'b0;
      tx_en_q    <= 1'b0;
      fstart_q   <= 1'b0;
      fdone_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      tx_bit_q   <= tx_bit_d;
      tx_en_q    <= tx_en_d;
      fstart_q   <= fstart_d;
      fdone_q    <= fdone_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.tx_bit      = tx_bit_q;
  assign bus.tx_en       = tx_en_q;
  assign bus.frame_start = fstart_q;
  assign bus.frame_done  = fdone_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_dcs_tx_serializer.sv
// Scoreboard bench for dcs_tx_serializer: default build plus a GAP_CYCLES=0, 8-bit sync build.
module tb_dcs_tx_serializer;
  import dcs_pkg::*;

  typedef struct packed {
    logic b;
    logic first;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic reset, reset2;
  always #5 clk = ~clk;

  dcs_tx_serializer_if #(.DATA_W(96)) bus ();
  dcs_tx_serializer_if #(.DATA_W(96)) bus2 ();

  dcs_tx_serializer #(
    .DATA_W(96), .SYNC_W(16), .SYNC_WORD(16'hF0A5), .GAP_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  dcs_tx_serializer #(
    .DATA_W(96), .SYNC_W(8), .SYNC_WORD(8'hC3), .GAP_CYCLES(0)
  ) dut_g0 (
    .clk(clk), .reset(reset2), .bus(bus2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  exp_t sb_q[$];
  int   ncyc = 0;
  int   acc_q[$], fs_q[$], fd_q[$], lr_q[$], en_q[$], rdy_q[$];
  int   low_run = 0, en_run = 0;
  logic prev_rdy = 1'b1, prev_en = 1'b0;

  task automatic push_frame(input logic [95:0] d);
    logic [15:0] s;
    exp_t e;
    s = 16'hF0A5;
    for (int i = 15; i >= 0; i--) begin
      e.b = s[i]; e.first = (i == 15); e.last = 1'b0;
      sb_q.push_back(e);
    end
    for (int i = 95; i >= 0; i--) begin
      e.b = d[i]; e.first = 1'b0; e.last = (i == 0);
      sb_q.push_back(e);
    end
  endtask

  task automatic clear_q();
    acc_q.delete(); fs_q.delete(); fd_q.delete();
    lr_q.delete(); en_q.delete(); rdy_q.delete();
  endtask

  // Expected frames enter the scoreboard on the handshake; every tx_en cycle pops one bit.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (bus.in_valid && bus.in_ready && !reset) begin
        acc_q.push_back(ncyc);
        push_frame(bus.in_data);
      end
      if (bus.tx_en) begin
        if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb_q.pop_front();
          chk("tx_bit", bus.tx_bit, e.b);
          chk("frame_start", bus.frame_start, e.first);
          chk("frame_done", bus.frame_done, e.last);
        end
        if (bus.frame_start) lr_q.push_back(low_run);
        low_run = 0;
        en_run++;
      end else begin
        chk("idle_tx_bit", bus.tx_bit, 0);
        chk("idle_frame_start", bus.frame_start, 0);
        chk("idle_frame_done", bus.frame_done, 0);
        if (prev_en) en_q.push_back(en_run);
        en_run = 0;
        low_run++;
      end
      if (bus.frame_start) fs_q.push_back(ncyc);
      if (bus.frame_done) fd_q.push_back(ncyc);
      if (bus.in_ready && !prev_rdy) rdy_q.push_back(ncyc);
      prev_rdy = bus.in_ready;
      prev_en  = bus.tx_en;
    end
  end

  int   n2 = 0, pos2 = 0, low2 = 0;
  int   fs2_q[$], lr2_q[$];
  logic [7:0] sync2;

  initial begin
    sync2 = 8'hC3;
    forever begin
      @(negedge clk);
      n2++;
      if (bus2.tx_en) begin
        if (bus2.frame_start) begin
          pos2 = 0;
          fs2_q.push_back(n2);
          lr2_q.push_back(low2);
        end
        if (pos2 < 8) chk("g0_sync_bit", bus2.tx_bit, sync2[7-pos2]);
        pos2++;
        low2 = 0;
      end else begin
        low2++;
      end
    end
  end

  task automatic wait_acc(input int n);
    for (int i = 0; i < 400 && acc_q.size() < n; i++) begin
      @(posedge clk); #1;
    end
    if (acc_q.size() < n) chk("accept_timeout", acc_q.size(), n);
  endtask

  task automatic send_one(input logic [95:0] d);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    wait_acc(1);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rel;
    reset = 1'b1; reset2 = 1'b1;
    bus.in_valid  = 1'b0; bus.in_data  = '0;
    bus2.in_valid = 1'b1; bus2.in_data = 96'hDEAD_BEEF_0123_4567_89AB_CDEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_tx_en", bus.tx_en, 0);
    chk("rst_tx_bit", bus.tx_bit, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_frame_start", bus.frame_start, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    @(posedge clk); #1;
    reset = 1'b0; reset2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single word, pulsed valid
    clear_q();
    send_one(96'hFFFF_0000_AAAA_5555_1234_5678);
    repeat (120) @(negedge clk);
    chk("t1_accepts", acc_q.size(), 1);
    chk("t1_fs_latency", fs_q[0] - acc_q[0], 1);
    chk("t1_fd_latency", fd_q[0] - acc_q[0], 112);
    chk("t1_ready_after_fd", rdy_q[0] - fd_q[0], 3);
    chk("t1_tx_en_len", en_q[0], 112);
    chk("t1_sb_empty", sb_q.size(), 0);

    // Back-to-back with valid held
    @(posedge clk); #1;
    clear_q();
    bus.in_data  = 96'h1;
    bus.in_valid = 1'b1;
    wait_acc(1);
    bus.in_data = {1'b1, 95'b0};
    wait_acc(2);
    bus.in_valid = 1'b0;
    repeat (120) @(negedge clk);
    chk("t2_accept_period", acc_q[1] - acc_q[0], 115);
    chk("t2_fs_period", fs_q[1] - fs_q[0], 115);
    chk("t2_low_between", lr_q[1], 3);
    chk("t2_tx_en_len", en_q[1], 112);
    chk("t2_sb_empty", sb_q.size(), 0);

    // Valid toggling and data changing mid-payload
    @(posedge clk); #1;
    clear_q();
    send_one(96'h0123_4567_89AB_CDEF_FEDC_BA98);
    repeat (30) @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      bus.in_valid = i[0];
      bus.in_data  = {$urandom, $urandom, $urandom};
      @(negedge clk);
      chk("t3_in_ready_low", bus.in_ready, 0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (60) @(negedge clk);
    chk("t3_accepts", acc_q.size(), 1);
    chk("t3_frames_done", fd_q.size(), 1);
    chk("t3_tx_en_len", en_q[0], 112);
    chk("t3_sb_empty", sb_q.size(), 0);

    // Reset in the middle of the payload
    @(posedge clk); #1;
    clear_q();
    send_one(96'hCAFE_F00D_0000_FFFF_5A5A_A5A5);
    repeat (55) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    sb_q.delete();
    @(negedge clk);
    chk("t4_tx_en", bus.tx_en, 0);
    chk("t4_busy", bus.busy, 0);
    chk("t4_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("t4_no_frame_done", fd_q.size(), 0);
    @(posedge clk); #1;
    clear_q();
    send_one(96'h8000_0000_0000_0000_0000_0001);
    repeat (120) @(negedge clk);
    chk("t4_post_fd_latency", fd_q[0] - acc_q[0], 112);
    chk("t4_post_tx_en_len", en_q[0], 112);
    chk("t4_sb_empty", sb_q.size(), 0);

    // Reset and valid on the same edge
    @(posedge clk); #1;
    clear_q();
    reset = 1'b1;
    bus.in_data  = 96'h1357_9BDF_2468_ACE0_0F0F_F0F0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    chk("t6_no_accept_in_reset", acc_q.size(), 0);
    reset = 1'b0;
    rel = ncyc;
    wait_acc(1);
    bus.in_valid = 1'b0;
    chk("t6_accept_cycle", acc_q[0], rel + 1);
    repeat (120) @(negedge clk);
    chk("t6_frame_starts", fs_q.size(), 1);
    chk("t6_fs_latency", fs_q[0] - acc_q[0], 1);
    chk("t6_tx_en_len", en_q[0], 112);
    chk("t6_sb_empty", sb_q.size(), 0);

    // Zero-gap build running free the whole time
    chk("g0_enough_frames", fs2_q.size() >= 3, 1);
    chk("g0_period_1", fs2_q[1] - fs2_q[0], 105);
    chk("g0_period_2", fs2_q[2] - fs2_q[1], 105);
    chk("g0_low_between_1", lr2_q[1], 1);
    chk("g0_low_between_2", lr2_q[2], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
